// File: rtl/scic_cpu_core.sv
// Accumulator CPU core: fetch/decode/read/write sequencer over a single-port word memory.
// state  | meaning
// FETCH  | mem_address=PC, hold WAIT_CYCLES+1 cycles, latch IR, PC+1
// DECODE | one cycle, branch resolution, pick READ/WRITE or retire
// READ   | mem_address=operand, hold WAIT_CYCLES+1 cycles, update ACC, retire
// WRITE  | one cycle store of ACC to operand address, retire
module scic_cpu_core #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_rdata,
  output logic [15:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc_out,
  output logic [31:0] acc_out,
  output logic [1:0]  state_out,
  output logic        retire,
  output logic        illegal_op
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_READ   = 2'd2;
  localparam logic [1:0] S_WRITE  = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h7;
  localparam logic [3:0] OP_BR  = 4'h8;
  localparam logic [3:0] OP_BRZ = 4'h9;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [31:0] r_acc;
  logic [31:0] r_ir;
  logic [2:0]  r_wait;
  logic        r_illegal;

  logic [3:0]  w_opcode;
  logic [15:0] w_operand;
  logic        w_wait_done;
  logic        w_needs_read;
  logic        w_is_store;
  logic        w_legal;

  assign w_opcode     = r_ir[31:28];
  assign w_operand    = r_ir[15:0];
  assign w_wait_done  = (r_wait == WAIT_LAST);
  assign w_needs_read = (w_opcode == OP_ADD) || (w_opcode == OP_AND) || (w_opcode == OP_LD);
  assign w_is_store   = (w_opcode == OP_ST);
  assign w_legal      = w_needs_read || w_is_store || (w_opcode == OP_NOP) ||
                        (w_opcode == OP_BR) || (w_opcode == OP_BRZ);

  // Bus outputs decode registered state only; mem_rdata never reaches them.
  always_comb begin
    mem_address = r_pc;
    mem_we      = 1'b0;
    retire      = 1'b0;
    case (r_state)
      S_DECODE: retire = !w_needs_read && !w_is_store;
      S_READ: begin
        mem_address = w_operand;
        retire      = w_wait_done;
      end
      S_WRITE: begin
        mem_address = w_operand;
        mem_we      = 1'b1;
        retire      = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_wdata  = r_acc;
  assign pc_out     = r_pc;
  assign acc_out    = r_acc;
  assign state_out  = r_state;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_acc     <= 32'h0;
      r_ir      <= 32'h0;
      r_wait    <= 3'd0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_wait_done) begin
            r_ir    <= mem_rdata;
            r_pc    <= r_pc + 16'd1;
            r_wait  <= 3'd0;
            r_state <= S_DECODE;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        S_DECODE: begin
          r_wait <= 3'd0;
          if (!w_legal) r_illegal <= 1'b1;
          if (w_needs_read)    r_state <= S_READ;
          else if (w_is_store) r_state <= S_WRITE;
          else                 r_state <= S_FETCH;
          if (w_opcode == OP_BR) r_pc <= w_operand;
          if ((w_opcode == OP_BRZ) && (r_acc == 32'h0)) r_pc <= w_operand;
        end
        S_READ: begin
          if (w_wait_done) begin
            case (w_opcode)
              OP_ADD:  r_acc <= r_acc + mem_rdata;
              OP_AND:  r_acc <= r_acc & mem_rdata;
              default: r_acc <= mem_rdata;
            endcase
            r_wait  <= 3'd0;
            r_state <= S_FETCH;
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end
        default: begin
          r_wait  <= 3'd0;
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scic_cpu_core.sv
// Bench for scic_cpu_core: directed programs plus a random program checked against
// an instruction-level model with its own copy of memory.
module tb_scic_cpu_core;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_rdata;
  logic [15:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [15:0] pc_out;
  logic [31:0] acc_out;
  logic [1:0]  state_out;
  logic        retire;
  logic        illegal_op;

  logic [31:0] dut_mem [0:65535];
  logic [31:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_pc;
  logic [31:0] m_acc;
  logic        m_ill;

  always #5 clk = ~clk;

  scic_cpu_core #(.RESET_PC(16'h0000), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .pc_out(pc_out), .acc_out(acc_out),
    .state_out(state_out), .retire(retire), .illegal_op(illegal_op));

  assign mem_rdata = dut_mem[mem_address];
  always @(negedge clk) if (mem_we) dut_mem[mem_address] <= mem_wdata;

  // Two extra cores with different wait settings, each running the LD program from a tiny ROM.
  logic [31:0] rom [0:31];
  logic [15:0] w0_addr, w0_pc, w3_addr, w3_pc;
  logic [31:0] w0_rdata, w0_wdata, w0_acc, w3_rdata, w3_wdata, w3_acc;
  logic        w0_we, w0_ret, w0_ill, w3_we, w3_ret, w3_ill;
  logic [1:0]  w0_state, w3_state;

  assign w0_rdata = (w0_addr < 16'd32) ? rom[w0_addr[4:0]] : 32'h0;
  assign w3_rdata = (w3_addr < 16'd32) ? rom[w3_addr[4:0]] : 32'h0;

  scic_cpu_core #(.RESET_PC(16'h0000), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .mem_rdata(w0_rdata), .mem_address(w0_addr),
    .mem_wdata(w0_wdata), .mem_we(w0_we), .pc_out(w0_pc), .acc_out(w0_acc),
    .state_out(w0_state), .retire(w0_ret), .illegal_op(w0_ill));

  scic_cpu_core #(.RESET_PC(16'h0000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset_n(reset_n), .mem_rdata(w3_rdata), .mem_address(w3_addr),
    .mem_wdata(w3_wdata), .mem_we(w3_we), .pc_out(w3_pc), .acc_out(w3_acc),
    .state_out(w3_state), .retire(w3_ret), .illegal_op(w3_ill));

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      dut_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [31:0] d);
    dut_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    m_pc = 16'h0000;
    m_acc = 32'h0;
    m_ill = 1'b0;
  endtask

  // Executes one instruction in the model, then watches the DUT until it retires.
  task automatic run_instr();
    logic [31:0] ins;
    logic [15:0] fpc, a, ewa;
    logic [31:0] ewd;
    logic [3:0]  op;
    int lat, n, we_cnt, ew;
    bit got, dec_seen;
    ins = ref_mem[m_pc];
    fpc = m_pc;
    m_pc = m_pc + 16'd1;
    op = ins[31:28];
    a = ins[15:0];
    ew = 0; ewa = 16'h0; ewd = 32'h0;
    lat = W + 2;
    case (op)
      4'h0: ;
      4'h1: begin m_acc = m_acc + ref_mem[a]; lat = 2 * W + 3; end
      4'h2: begin m_acc = m_acc & ref_mem[a]; lat = 2 * W + 3; end
      4'h5: begin m_acc = ref_mem[a]; lat = 2 * W + 3; end
      4'h7: begin ew = 1; ewa = a; ewd = m_acc; ref_mem[a] = m_acc; lat = W + 3; end
      4'h8: m_pc = a;
      4'h9: if (m_acc == 32'h0) m_pc = a;
      default: m_ill = 1'b1;
    endcase
    n = 0; we_cnt = 0; got = 0; dec_seen = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (mem_we) begin
        we_cnt++;
        n_cmp++; if (mem_address !== ewa) begin n_bad++; $display("FAIL st_addr: got %h exp %h (pc %h)", mem_address, ewa, fpc); end
        n_cmp++; if (mem_wdata !== ewd) begin n_bad++; $display("FAIL st_wdata: got %h exp %h (pc %h)", mem_wdata, ewd, fpc); end
      end
      if (state_out === 2'd1 && !dec_seen) begin
        dec_seen = 1;
        n_cmp++; if (pc_out !== fpc + 16'd1) begin n_bad++; $display("FAIL pc_after_fetch: got %h exp %h", pc_out, fpc + 16'd1); end
      end
      if (retire === 1'b1) got = 1;
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL retire_timeout: got none exp retire (pc %h)", fpc); end
    n_cmp++; if (n !== lat) begin n_bad++; $display("FAIL latency: got %0d exp %0d (pc %h op %h)", n, lat, fpc, op); end
    n_cmp++; if (we_cnt !== ew) begin n_bad++; $display("FAIL we_count: got %0d exp %0d (pc %h)", we_cnt, ew, fpc); end
    @(posedge clk); #1;
    n_cmp++; if (pc_out !== m_pc) begin n_bad++; $display("FAIL pc: got %h exp %h (after pc %h)", pc_out, m_pc, fpc); end
    n_cmp++; if (acc_out !== m_acc) begin n_bad++; $display("FAIL acc: got %h exp %h (after pc %h)", acc_out, m_acc, fpc); end
    n_cmp++; if (illegal_op !== m_ill) begin n_bad++; $display("FAIL illegal: got %b exp %b", illegal_op, m_ill); end
    n_cmp++; if (state_out !== 2'd0 || retire !== 1'b0) begin n_bad++; $display("FAIL post_retire: state %0d retire %b exp 0 0", state_out, retire); end
  endtask

  task automatic test_reset();
    int k;
    clear_mem();
    put(16'h0000, 32'h5000_001D);
    put(16'h001D, 32'h0000_0004);
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({pc_out, acc_out, state_out, mem_we, retire, illegal_op} !== 53'h0)
      begin n_bad++; $display("FAIL reset_first: got pc %h acc %h st %h we %b ret %b ill %b exp all 0", pc_out, acc_out, state_out, mem_we, retire, illegal_op); end
    do_reset();
    k = 0;
    while (state_out !== 2'd2 && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (state_out !== 2'd2) begin n_bad++; $display("FAIL reach_read: got %0d exp 2", state_out); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({pc_out, acc_out, state_out, mem_we, retire, illegal_op} !== 53'h0)
      begin n_bad++; $display("FAIL reset_mid_read: got pc %h acc %h st %h we %b ret %b ill %b exp all 0", pc_out, acc_out, state_out, mem_we, retire, illegal_op); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_program();
    clear_mem();
    put(16'h0000, 32'h5000_001D);
    put(16'h0001, 32'h1000_001D);
    put(16'h0002, 32'h7000_00FC);
    put(16'h0003, 32'h8000_0000);
    put(16'h001D, 32'h0000_0004);
    do_reset();
    run_instr();
    n_cmp++; if (acc_out !== 32'd4 || pc_out !== 16'h0001) begin n_bad++; $display("FAIL ld_basic: got acc %h pc %h exp 4 1", acc_out, pc_out); end
    run_instr();
    n_cmp++; if (acc_out !== 32'd8) begin n_bad++; $display("FAIL add_basic: got %h exp 8", acc_out); end
    run_instr();
    n_cmp++; if (dut_mem[16'h00FC] !== 32'd8) begin n_bad++; $display("FAIL st_commit: got %h exp 8", dut_mem[16'h00FC]); end
    run_instr();
    n_cmp++; if (pc_out !== 16'h0000) begin n_bad++; $display("FAIL br_basic: got %h exp 0", pc_out); end
  endtask

  task automatic test_carry_brz();
    clear_mem();
    put(16'h0000, 32'h5000_0020);
    put(16'h0001, 32'h1000_0021);
    put(16'h0002, 32'h9000_0010);
    put(16'h0003, 32'h5000_0022);
    put(16'h0004, 32'h9000_0010);
    put(16'h0020, 32'hFFFF_FFFE);
    put(16'h0021, 32'h0000_0004);
    do_reset();
    run_instr();
    run_instr();
    n_cmp++; if (acc_out !== 32'h0000_0002) begin n_bad++; $display("FAIL add_carry: got %h exp 00000002", acc_out); end
    run_instr();
    n_cmp++; if (pc_out !== 16'h0003) begin n_bad++; $display("FAIL brz_not_taken: got %h exp 0003", pc_out); end
    run_instr();
    run_instr();
    n_cmp++; if (pc_out !== 16'h0010) begin n_bad++; $display("FAIL brz_taken: got %h exp 0010", pc_out); end
  endtask

  task automatic test_wrap_illegal();
    clear_mem();
    put(16'h0000, 32'h8000_FFFF);
    put(16'hFFFF, 32'h0000_0000);
    do_reset();
    run_instr();
    n_cmp++; if (pc_out !== 16'hFFFF) begin n_bad++; $display("FAIL br_ffff: got %h exp ffff", pc_out); end
    put(16'h0000, 32'hF000_0000);
    put(16'h0002, 32'h1000_0100);
    put(16'h0100, 32'h0000_0003);
    run_instr();
    n_cmp++; if (pc_out !== 16'h0000) begin n_bad++; $display("FAIL pc_wrap: got %h exp 0000", pc_out); end
    run_instr();
    n_cmp++; if (illegal_op !== 1'b1) begin n_bad++; $display("FAIL illegal_set: got %b exp 1", illegal_op); end
    for (int i = 0; i < 3; i++) begin
      run_instr();
      n_cmp++; if (illegal_op !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky%0d: got %b exp 1", i, illegal_op); end
    end
  endtask

  task automatic test_reset_in_write();
    int k;
    clear_mem();
    put(16'h0000, 32'h5000_001D);
    put(16'h0001, 32'h7000_0050);
    put(16'h001D, 32'h0000_0004);
    do_reset();
    run_instr();
    k = 0;
    while (state_out !== 2'd3 && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (state_out !== 2'd3) begin n_bad++; $display("FAIL reach_write: got %0d exp 3", state_out); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (state_out !== 2'd0 || mem_we !== 1'b0 || acc_out !== 32'h0 || pc_out !== 16'h0000)
      begin n_bad++; $display("FAIL reset_in_write: got st %0d we %b acc %h pc %h exp 0 0 0 0", state_out, mem_we, acc_out, pc_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_latency_w0_w3();
    int lat0, lat3;
    logic [15:0] pc0, pc3;
    logic [31:0] acc0, acc3;
    do_reset();
    lat0 = 0; lat3 = 0; pc0 = 16'hDEAD; pc3 = 16'hDEAD; acc0 = 32'h0; acc3 = 32'h0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (lat0 != 0 && n == lat0 + 1) begin
        pc0 = w0_pc; acc0 = w0_acc;
        n_cmp++; if (w0_state !== 2'd0 || w0_we !== 1'b0 || w0_ill !== 1'b0 || w0_wdata !== 32'd4)
          begin n_bad++; $display("FAIL w0_misc: got st %0d we %b ill %b wd %h exp 0 0 0 4", w0_state, w0_we, w0_ill, w0_wdata); end
      end
      if (lat3 != 0 && n == lat3 + 1) begin
        pc3 = w3_pc; acc3 = w3_acc;
        n_cmp++; if (w3_state !== 2'd0 || w3_we !== 1'b0 || w3_ill !== 1'b0 || w3_wdata !== 32'd4)
          begin n_bad++; $display("FAIL w3_misc: got st %0d we %b ill %b wd %h exp 0 0 0 4", w3_state, w3_we, w3_ill, w3_wdata); end
      end
      if (w0_ret === 1'b1 && lat0 == 0) lat0 = n;
      if (w3_ret === 1'b1 && lat3 == 0) lat3 = n;
    end
    n_cmp++; if (lat0 !== 3) begin n_bad++; $display("FAIL ld_latency_w0: got %0d exp 3", lat0); end
    n_cmp++; if (lat3 !== 9) begin n_bad++; $display("FAIL ld_latency_w3: got %0d exp 9", lat3); end
    n_cmp++; if (acc0 !== 32'd4 || pc0 !== 16'd1) begin n_bad++; $display("FAIL w0_result: got acc %h pc %h exp 4 1", acc0, pc0); end
    n_cmp++; if (acc3 !== 32'd4 || pc3 !== 16'd1) begin n_bad++; $display("FAIL w3_result: got acc %h pc %h exp 4 1", acc3, pc3); end
  endtask

  task automatic test_random_program();
    logic [3:0] ops [0:11];
    logic [3:0] op;
    logic [15:0] a;
    ops = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h7, 4'h8, 4'h9, 4'h3, 4'h4, 4'h6, 4'hA, 4'hF};
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      op = ops[$urandom_range(0, 11)];
      if (op == 4'h8 || op == 4'h9) a = 16'($urandom_range(0, 63));
      else a = 16'h0100 + 16'($urandom_range(0, 63));
      put(16'(i), {op, 12'($urandom), a});
      put(16'h0100 + 16'(i), ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
    end
    do_reset();
    for (int i = 0; i < 200; i++) run_instr();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;
    rom[0]  = 32'h5000_001D;
    rom[29] = 32'h0000_0004;
    clear_mem();
    test_reset();
    test_basic_program();
    test_carry_brz();
    test_wrap_illegal();
    test_reset_in_write();
    test_latency_w0_w3();
    test_random_program();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
